// File: rtl/alu_ctrl_decoder.sv
// -----------------------------------------------------------------------------
// alu_ctrl_decoder
//   Registered RV32I decode stage between fetch and execute. Turns one raw
//   instruction per valid/ready beat into the 6-bit ALU_Control code, operand
//   selects, immediate, register indices and control strobes. The result is
//   held in a single pipeline register with back-pressure and flush.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   flush             kill the held entry and the one accepted this cycle
//   in_valid/in_ready upstream handshake (instruction, pc_in)
//   out_valid/out_ready downstream handshake for the decoded entry
//   ALU_Control       ALU operation code
//   A_sel             operand A: 00 rs1, 01 PC, 10 zero
//   B_sel             operand B: 0 rs2, 1 imm
//   imm               sign-extended immediate (zero-extended shamt for shifts)
//   rs1, rs2, rd      register indices
//   reg_write, mem_read, mem_write, branch, jump   control strobes
//   illegal           (ILLEGAL_TRAP_EN only) entry holds an unsupported encoding
//   pc_out            pc_in carried with the entry
//
// Configuration
//   ILLEGAL_TRAP_EN   defined: illegal encodings are flagged on the illegal
//                     port, ALU_Control=6'b111111 and all strobes cleared.
//                     undefined: illegal encodings decode exactly as NOP_INSTR.
// -----------------------------------------------------------------------------
module alu_ctrl_decoder #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter logic [5:0]  PASS_CODE = 6'b011111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instruction,
    input  logic [31:0] pc_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  ALU_Control,
    output logic [1:0]  A_sel,
    output logic        B_sel,
    output logic [31:0] imm,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        branch,
    output logic        jump,
`ifdef ILLEGAL_TRAP_EN
    output logic        illegal,
`endif
    output logic [31:0] pc_out
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [5:0]  alu;
        logic [1:0]  a_sel;
        logic        b_sel;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
    } dec_t;

    // Anything outside the supported RV32I subset.
    function automatic logic is_illegal(input logic [31:0] ins);
        logic [2:0] f3;
        logic [6:0] f7;
        logic       bad;
        f3  = ins[14:12];
        f7  = ins[31:25];
        bad = 1'b1;
        case (ins[6:0])
            OP_LUI, OP_AUIPC, OP_JAL: bad = 1'b0;
            OP_JALR:                  bad = (f3 != 3'b000);
            OP_BRANCH:                bad = (f3[2:1] != 2'b00);      // only BEQ/BNE
            OP_LOAD, OP_STORE:        bad = (f3 != 3'b010);          // word only
            OP_IMM: begin
                case (f3)
                    3'b010, 3'b011: bad = 1'b1;                      // SLTI/SLTIU
                    3'b001:         bad = (f7 != F7_BASE);
                    3'b101:         bad = (f7 != F7_BASE) && (f7 != F7_ALT);
                    default:        bad = 1'b0;
                endcase
            end
            OP_REG: begin
                if (f7 == F7_BASE)
                    bad = (f3 == 3'b010) || (f3 == 3'b011);          // SLT/SLTU
                else if (f7 == F7_ALT)
                    bad = (f3 != 3'b000) && (f3 != 3'b101);          // only SUB/SRA
                else
                    bad = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Field decode; result is meaningful only for legal encodings.
    function automatic dec_t decode(input logic [31:0] ins);
        dec_t       d;
        logic [2:0] f3;
        logic [31:0] imm_i;
        f3    = ins[14:12];
        imm_i = {{20{ins[31]}}, ins[31:20]};
        // NOTE: every field gets a default first so no path leaves one
        // unassigned; in combinational context that would infer a latch.
        d = '0;
        case (ins[6:0])
            OP_LUI: begin
                d.a_sel = 2'b10;
                d.b_sel = 1'b1;
                d.imm   = {ins[31:12], 12'b0};
                d.rd    = ins[11:7];
                d.reg_write = 1'b1;
            end
            OP_AUIPC: begin
                d.a_sel = 2'b01;
                d.b_sel = 1'b1;
                d.imm   = {ins[31:12], 12'b0};
                d.rd    = ins[11:7];
                d.reg_write = 1'b1;
            end
            OP_JAL: begin
                d.alu   = PASS_CODE;
                d.a_sel = 2'b01;
                d.b_sel = 1'b1;
                d.imm   = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
                d.rd    = ins[11:7];
                d.reg_write = 1'b1;
                d.jump  = 1'b1;
            end
            OP_JALR: begin
                d.alu   = PASS_CODE;
                d.a_sel = 2'b01;
                d.b_sel = 1'b1;
                d.imm   = imm_i;
                d.rs1   = ins[19:15];
                d.rd    = ins[11:7];
                d.reg_write = 1'b1;
                d.jump  = 1'b1;
            end
            OP_BRANCH: begin
                d.alu    = {5'b01000, f3[0]};
                d.imm    = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
                d.rs1    = ins[19:15];
                d.rs2    = ins[24:20];
                d.branch = 1'b1;
            end
            OP_LOAD: begin
                d.b_sel = 1'b1;
                d.imm   = imm_i;
                d.rs1   = ins[19:15];
                d.rd    = ins[11:7];
                d.reg_write = 1'b1;
                d.mem_read  = 1'b1;
            end
            OP_STORE: begin
                d.b_sel = 1'b1;
                d.imm   = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                d.rs1   = ins[19:15];
                d.rs2   = ins[24:20];
                d.mem_write = 1'b1;
            end
            OP_IMM: begin
                // Only the right shift carries an ALU opcode bit in funct7.
                d.alu   = (f3 == 3'b101) ? {2'b00, ins[30], f3} : {3'b000, f3};
                d.b_sel = 1'b1;
                d.imm   = (f3[1:0] == 2'b01) ? {27'b0, ins[24:20]} : imm_i;
                d.rs1   = ins[19:15];
                d.rd    = ins[11:7];
                d.reg_write = 1'b1;
            end
            OP_REG: begin
                d.alu = {2'b00, ins[30], f3};
                d.rs1 = ins[19:15];
                d.rs2 = ins[24:20];
                d.rd  = ins[11:7];
                d.reg_write = 1'b1;
            end
            default: d = '0;
        endcase
        d.reg_write = d.reg_write && (d.rd != 5'd0);
        return d;
    endfunction

    logic accept;
    logic bad_instr;
    dec_t dec_next;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        bad_instr = is_illegal(instruction);
`ifdef ILLEGAL_TRAP_EN
        dec_next = decode(instruction);
        if (bad_instr) begin
            dec_next.alu       = 6'b111111;
            dec_next.reg_write = 1'b0;
            dec_next.mem_read  = 1'b0;
            dec_next.mem_write = 1'b0;
            dec_next.branch    = 1'b0;
            dec_next.jump      = 1'b0;
        end
`else
        dec_next = decode(bad_instr ? NOP_INSTR : instruction);
`endif
    end

    // NOTE: state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            ALU_Control <= '0;
            A_sel       <= '0;
            B_sel       <= 1'b0;
            imm         <= '0;
            rs1         <= '0;
            rs2         <= '0;
            rd          <= '0;
            reg_write   <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            branch      <= 1'b0;
            jump        <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal     <= 1'b0;
`endif
            pc_out      <= '0;
        end else begin
            if (flush)          out_valid <= 1'b0;
            else if (accept)    out_valid <= 1'b1;
            else if (out_ready) out_valid <= 1'b0;

            // Data loads on every accept; after a flush it is simply unused.
            if (accept) begin
                ALU_Control <= dec_next.alu;
                A_sel       <= dec_next.a_sel;
                B_sel       <= dec_next.b_sel;
                imm         <= dec_next.imm;
                rs1         <= dec_next.rs1;
                rs2         <= dec_next.rs2;
                rd          <= dec_next.rd;
                reg_write   <= dec_next.reg_write;
                mem_read    <= dec_next.mem_read;
                mem_write   <= dec_next.mem_write;
                branch      <= dec_next.branch;
                jump        <= dec_next.jump;
`ifdef ILLEGAL_TRAP_EN
                illegal     <= bad_instr;
`endif
                pc_out      <= pc_in;
            end
        end
    end

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// -----------------------------------------------------------------------------
// tb_alu_ctrl_decoder
//   Directed bench for alu_ctrl_decoder. Each task drives one scenario and
//   compares outputs against hand-computed values. Builds with or without
//   ILLEGAL_TRAP_EN.
// -----------------------------------------------------------------------------
module tb_alu_ctrl_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic [31:0] pc_in;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  alu_control;
    logic [1:0]  a_sel;
    logic        b_sel;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        reg_write, mem_read, mem_write, branch, jump;
`ifdef ILLEGAL_TRAP_EN
    logic        illegal;
`endif
    logic [31:0] pc_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_ctrl_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instruction (instruction),
        .pc_in       (pc_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ALU_Control (alu_control),
        .A_sel       (a_sel),
        .B_sel       (b_sel),
        .imm         (imm),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .reg_write   (reg_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .branch      (branch),
        .jump        (jump),
`ifdef ILLEGAL_TRAP_EN
        .illegal     (illegal),
`endif
        .pc_out      (pc_out)
    );

    // Advance one edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted beat with the sink ready.
    task automatic send(input logic [31:0] ins, input logic [31:0] pc);
        flush       = 1'b0;
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        instruction = ins;
        pc_in       = pc;
        tick();
        in_valid    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instruction = 32'h0; pc_in = 32'h0;
        tick(); tick();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
        n_tests++;
        if ({alu_control, a_sel, b_sel, imm, rd, reg_write, jump, pc_out} !== '0)
            begin n_fail++; $display("FAIL reset_fields: got alu=%b imm=%h pc=%h", alu_control, imm, pc_out); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_r_type();
        send(32'h002081B3, 32'h0000_1000);           // ADD x3,x1,x2
        n_tests++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b exp 1", out_valid); end
        n_tests++;
        if ({alu_control, a_sel, b_sel} !== {6'b000000, 2'b00, 1'b0})
            begin n_fail++; $display("FAIL add_ctrl: got %b/%b/%b exp 000000/00/0", alu_control, a_sel, b_sel); end
        n_tests++;
        if ({rs1, rs2, rd, reg_write, pc_out} !== {5'd1, 5'd2, 5'd3, 1'b1, 32'h0000_1000})
            begin n_fail++; $display("FAIL add_regs: got rs1=%0d rs2=%0d rd=%0d rw=%b pc=%h", rs1, rs2, rd, reg_write, pc_out); end
        send(32'h402081B3, 32'h0000_1004);           // SUB
        n_tests++;
        if (alu_control !== 6'b001000) begin n_fail++; $display("FAIL sub_alu: got %b exp 001000", alu_control); end
        send(32'h002091B3, 32'h0000_1008);           // SLL
        n_tests++;
        if (alu_control !== 6'b000001) begin n_fail++; $display("FAIL sll_alu: got %b exp 000001", alu_control); end
        send(32'h00208033, 32'h0000_100C);           // ADD x0,x1,x2
        n_tests++;
        if ({rd, reg_write} !== {5'd0, 1'b0}) begin n_fail++; $display("FAIL add_x0_rw: got rd=%0d rw=%b exp 0/0", rd, reg_write); end
    endtask

    task automatic test_i_type();
        send(32'h40335293, 32'h0000_2000);           // SRAI x5,x6,3
        n_tests++;
        if ({alu_control, b_sel, imm} !== {6'b001101, 1'b1, 32'h3})
            begin n_fail++; $display("FAIL srai: got alu=%b b=%b imm=%h exp 001101/1/3", alu_control, b_sel, imm); end
        n_tests++;
        if ({rs1, rd, rs2} !== {5'd6, 5'd5, 5'd0})
            begin n_fail++; $display("FAIL srai_regs: got rs1=%0d rd=%0d rs2=%0d exp 6/5/0", rs1, rd, rs2); end
        send(32'hFFF00293, 32'h0000_2004);           // ADDI x5,x0,-1
        n_tests++;
        if ({alu_control, b_sel, imm, reg_write} !== {6'b000000, 1'b1, 32'hFFFF_FFFF, 1'b1})
            begin n_fail++; $display("FAIL addi_neg: got alu=%b imm=%h rw=%b", alu_control, imm, reg_write); end
    endtask

    task automatic test_branch_mem_jump();
        send(32'h00208463, 32'h0000_3000);           // BEQ x1,x2,+8
        n_tests++;
        if ({alu_control, branch, imm, reg_write, rd, b_sel} !== {6'b010000, 1'b1, 32'h8, 1'b0, 5'd0, 1'b0})
            begin n_fail++; $display("FAIL beq: got alu=%b br=%b imm=%h rw=%b rd=%0d", alu_control, branch, imm, reg_write, rd); end
        send(32'h0020A223, 32'h0000_3004);           // SW x2,4(x1)
        n_tests++;
        if ({mem_write, mem_read, imm, rd, rs2, reg_write} !== {1'b1, 1'b0, 32'h4, 5'd0, 5'd2, 1'b0})
            begin n_fail++; $display("FAIL sw: got mw=%b mr=%b imm=%h rd=%0d rs2=%0d", mem_write, mem_read, imm, rd, rs2); end
        send(32'h010000EF, 32'h0000_3008);           // JAL x1,+16
        n_tests++;
        if ({alu_control, a_sel, jump, reg_write, imm, rd} !== {6'b011111, 2'b01, 1'b1, 1'b1, 32'h10, 5'd1})
            begin n_fail++; $display("FAIL jal: got alu=%b a=%b j=%b rw=%b imm=%h", alu_control, a_sel, jump, reg_write, imm); end
        send(32'h123450B7, 32'h0000_300C);           // LUI x1,0x12345
        n_tests++;
        if ({alu_control, a_sel, b_sel, imm} !== {6'b000000, 2'b10, 1'b1, 32'h1234_5000})
            begin n_fail++; $display("FAIL lui: got alu=%b a=%b b=%b imm=%h", alu_control, a_sel, b_sel, imm); end
    endtask

    task automatic test_stall();
        send(32'h402081B3, 32'h0000_0100);           // SUB, held
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        instruction = 32'h0020F1B3;                  // AND waiting upstream
        pc_in       = 32'h0000_0104;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if ({out_valid, in_ready, alu_control, pc_out} !== {1'b1, 1'b0, 6'b001000, 32'h0000_0100})
                begin n_fail++; $display("FAIL stall_hold[%0d]: got v=%b rdy=%b alu=%b pc=%h", i, out_valid, in_ready, alu_control, pc_out); end
        end
        out_ready = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b exp 1", in_ready); end
        tick();
        n_tests++;
        if ({out_valid, alu_control, pc_out} !== {1'b1, 6'b000111, 32'h0000_0104})
            begin n_fail++; $display("FAIL release_load: got v=%b alu=%b pc=%h", out_valid, alu_control, pc_out); end
        in_valid = 1'b0;
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL retire_empty: got %b exp 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins_tab [6] = '{32'h002081B3, 32'h402081B3, 32'h0020C1B3,
                                     32'h0020E1B3, 32'h0020D1B3, 32'h4020D1B3};
        logic [5:0]  alu_tab [6] = '{6'b000000, 6'b001000, 6'b000100,
                                     6'b000110, 6'b000101, 6'b001101};
        out_ready = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            instruction = ins_tab[i];
            pc_in       = 32'h0000_4000 + 32'(i * 4);
            tick();
            n_tests++;
            if ({out_valid, alu_control, pc_out} !== {1'b1, alu_tab[i], 32'h0000_4000 + 32'(i * 4)})
                begin n_fail++; $display("FAIL b2b[%0d]: got v=%b alu=%b pc=%h exp alu=%b", i, out_valid, alu_control, pc_out, alu_tab[i]); end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        send(32'h002081B3, 32'h0000_5000);
        flush       = 1'b1;
        in_valid    = 1'b1;
        instruction = 32'h402081B3;
        pc_in       = 32'h0000_5004;
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_accept: got %b exp 0", out_valid); end
        flush = 1'b0;
        send(32'h002081B3, 32'h0000_5008);
        out_ready = 1'b0;
        flush     = 1'b1;
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b exp 0", out_valid); end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_illegal();
        for (int k = 0; k < 2; k++) begin
            // SLT, then an R-type with funct7=0000001
            send(k == 0 ? 32'h0020A1B3 : 32'h022081B3, 32'h0000_6000 + 32'(k * 4));
`ifdef ILLEGAL_TRAP_EN
            n_tests++;
            if ({illegal, reg_write, alu_control, mem_read, mem_write, branch, jump} !== {1'b1, 1'b0, 6'b111111, 4'b0000})
                begin n_fail++; $display("FAIL illegal_trap[%0d]: got ill=%b rw=%b alu=%b", k, illegal, reg_write, alu_control); end
`else
            n_tests++;
            if ({alu_control, rd, reg_write, b_sel, imm, a_sel} !== {6'b000000, 5'd0, 1'b0, 1'b1, 32'h0, 2'b00})
                begin n_fail++; $display("FAIL illegal_nop[%0d]: got alu=%b rd=%0d rw=%b imm=%h", k, alu_control, rd, reg_write, imm); end
`endif
            n_tests++;
            if ({out_valid, pc_out} !== {1'b1, 32'h0000_6000 + 32'(k * 4)})
                begin n_fail++; $display("FAIL illegal_pc[%0d]: got v=%b pc=%h", k, out_valid, pc_out); end
        end
        send(32'h002081B3, 32'h0000_6010);
`ifdef ILLEGAL_TRAP_EN
        n_tests++;
        if (illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_clear: got %b exp 0", illegal); end
`endif
        n_tests++;
        if ({alu_control, rd, reg_write} !== {6'b000000, 5'd3, 1'b1})
            begin n_fail++; $display("FAIL legal_after_illegal: got alu=%b rd=%0d rw=%b", alu_control, rd, reg_write); end
    endtask

    task automatic test_async_reset();
        send(32'h402081B3, 32'h0000_7000);
        out_ready = 1'b0;
        #2;                                          // mid-cycle, no edge near
        reset = 1'b1;
        #1;
        n_tests++;
        if ({out_valid, alu_control, pc_out} !== {1'b0, 6'b000000, 32'h0})
            begin n_fail++; $display("FAIL async_reset: got v=%b alu=%b pc=%h", out_valid, alu_control, pc_out); end
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_r_type();
        test_i_type();
        test_branch_mem_jump();
        test_stall();
        test_back_to_back();
        test_flush();
        test_illegal();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
